// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module   : cpu_ctrl_pkg
// Brief    : State encoding, opcodes and ALU control codes for the LEGv8
//            multicycle controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    ALU_WB   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    LD_WB    = 4'd6,
    MEM_WR   = 4'd7,
    BRANCH   = 4'd8,
    ILLEGAL  = 4'd9
  } state_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  function automatic logic is_rtype(input logic [10:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// ============================================================================
// Module   : alu_decoder
// Brief    : Maps an R-type opcode to its ALU operation; ADD otherwise.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [10:0] op_i,
  output logic [3:0]  alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (op_i)
      OP_ADD:  alu_control_o = ALU_ADD;
      OP_SUB:  alu_control_o = ALU_SUB;
      OP_AND:  alu_control_o = ALU_AND;
      OP_ORR:  alu_control_o = ALU_ORR;
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Brief    : Main control FSM of the multicycle LEGv8 core with memory
//            ready/wait handshake and retired-instruction counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      op_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             pc_src_o,
  output logic             ir_write_o,
  output logic             iord_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             reg2loc_o,
  output logic             alu_src_o,
  output logic [3:0]       alu_control_o,
  output logic             reg_write_o,
  output logic             mem_to_reg_o,
  output logic             exc_o,
  output logic [CNT_W-1:0] instr_count_o
);

  state_t           r_state;
  state_t           w_next;
  logic             w_retire;
  logic [3:0]       w_alu_r;
  logic [CNT_W-1:0] r_count;

  logic w_is_rtype;
  logic w_is_ldur;
  logic w_is_stur;
  logic w_is_cbz;

  assign w_is_rtype = is_rtype(op_i);
  assign w_is_ldur  = (op_i == OP_LDUR);
  assign w_is_stur  = (op_i == OP_STUR);
  assign w_is_cbz   = (op_i[10:3] == OP_CBZ);

  alu_decoder u_alu_decoder (
    .op_i          (op_i),
    .alu_control_o (w_alu_r)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_count <= r_count + CNT_W'(1);
    end
  end

  assign instr_count_o = r_count;

  always_comb begin
    pc_write_o    = 1'b0;
    pc_src_o      = 1'b0;
    ir_write_o    = 1'b0;
    iord_o        = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    reg2loc_o     = 1'b0;
    alu_src_o     = 1'b0;
    alu_control_o = 4'b0000;
    reg_write_o   = 1'b0;
    mem_to_reg_o  = 1'b0;
    exc_o         = 1'b0;
    w_retire      = 1'b0;
    w_next        = r_state;

    case (r_state)
      FETCH: begin
        mem_read_o = 1'b1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          w_next     = DECODE;
        end
      end
      DECODE: begin
        reg2loc_o = w_is_stur | w_is_cbz;
        if (w_is_rtype)                  w_next = EXEC_R;
        else if (w_is_ldur || w_is_stur) w_next = MEM_ADDR;
        else if (w_is_cbz)               w_next = BRANCH;
        else                             w_next = ILLEGAL;
      end
      EXEC_R: begin
        alu_control_o = w_alu_r;
        w_next        = ALU_WB;
      end
      ALU_WB: begin
        reg_write_o = 1'b1;
        w_retire    = 1'b1;
        w_next      = FETCH;
      end
      MEM_ADDR: begin
        alu_src_o     = 1'b1;
        alu_control_o = ALU_ADD;
        reg2loc_o     = w_is_stur;
        w_next        = w_is_ldur ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        if (mem_ready_i) w_next = LD_WB;
      end
      LD_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        w_retire     = 1'b1;
        w_next       = FETCH;
      end
      MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        reg2loc_o   = 1'b1;
        if (mem_ready_i) begin
          w_retire = 1'b1;
          w_next   = FETCH;
        end
      end
      BRANCH: begin
        reg2loc_o     = 1'b1;
        alu_control_o = ALU_PASSB;
        if (zero_i) begin
          pc_write_o = 1'b1;
          pc_src_o   = 1'b1;
        end
        w_retire = 1'b1;
        w_next   = FETCH;
      end
      ILLEGAL: begin
        exc_o = 1'b1;
      end
      default: w_next = FETCH;
    endcase

    // A reset cycle aborts the current instruction: no write, no retire.
    if (reset) begin
      pc_write_o    = 1'b0;
      pc_src_o      = 1'b0;
      ir_write_o    = 1'b0;
      iord_o        = 1'b0;
      mem_read_o    = 1'b1;
      mem_write_o   = 1'b0;
      reg2loc_o     = 1'b0;
      alu_src_o     = 1'b0;
      alu_control_o = 4'b0000;
      reg_write_o   = 1'b0;
      mem_to_reg_o  = 1'b0;
      exc_o         = 1'b0;
      w_retire      = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module   : tb_multicycle_controller
// Brief    : Randomized scoreboard bench for multicycle_controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

  localparam int CNT_W = 4;

  localparam logic [10:0] T_ADD  = 11'b10001011000;
  localparam logic [10:0] T_SUB  = 11'b11001011000;
  localparam logic [10:0] T_AND  = 11'b10001010000;
  localparam logic [10:0] T_ORR  = 11'b10101010000;
  localparam logic [10:0] T_LDUR = 11'b11111000010;
  localparam logic [10:0] T_STUR = 11'b11111000000;
  localparam logic [10:0] T_CBZ  = 11'b10110100000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [10:0]      op = '0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             pc_write, pc_src, ir_write, iord, mem_read, mem_write;
  logic             reg2loc, alu_src, reg_write, mem_to_reg, exc;
  logic [3:0]       alu_control;
  logic [CNT_W-1:0] instr_count;

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .op_i          (op),
    .zero_i        (zero),
    .mem_ready_i   (mem_ready),
    .pc_write_o    (pc_write),
    .pc_src_o      (pc_src),
    .ir_write_o    (ir_write),
    .iord_o        (iord),
    .mem_read_o    (mem_read),
    .mem_write_o   (mem_write),
    .reg2loc_o     (reg2loc),
    .alu_src_o     (alu_src),
    .alu_control_o (alu_control),
    .reg_write_o   (reg_write),
    .mem_to_reg_o  (mem_to_reg),
    .exc_o         (exc),
    .instr_count_o (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg2loc, alu_src;
    logic [3:0] alu;
    logic       reg_write, mem_to_reg, exc;
  } ctl_t;

  typedef struct packed {
    logic             skip;
    ctl_t             c;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   model_cnt = 0;

  ctl_t act;
  assign act = {pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg2loc, alu_src,
                alu_control, reg_write, mem_to_reg, exc};

  // Monitor: one expected entry per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (!e.skip) begin
        checks++;
        if (act !== e.c) begin
          failures++;
          $display("FAIL ctl op=%b actual=%h expected=%h t=%0t", op, act, e.c, $time);
        end
        checks++;
        if (instr_count !== e.cnt) begin
          failures++;
          $display("FAIL count actual=%0d expected=%0d t=%0t", instr_count, e.cnt, $time);
        end
      end
    end
  end

  logic [10:0] cur_op;
  int          idx;
  int          abort_at_g;
  bit          aborted;

  function automatic logic rz();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] r_alu(input logic [10:0] o);
    case (o)
      T_SUB:   return 4'b0110;
      T_AND:   return 4'b0000;
      T_ORR:   return 4'b0001;
      default: return 4'b0010;
    endcase
  endfunction

  // 0 R-type, 1 LDUR, 2 STUR, 3 CBZ, 4 illegal
  function automatic int classify(input logic [10:0] o);
    if (o == T_ADD || o == T_SUB || o == T_AND || o == T_ORR) return 0;
    if (o == T_LDUR) return 1;
    if (o == T_STUR) return 2;
    if (o[10:3] == T_CBZ[10:3]) return 3;
    return 4;
  endfunction

  task automatic drive(input logic z, input logic r, input logic rs, input ctl_t c, input logic skip);
    @(posedge clk);
    #1;
    op = cur_op; zero = z; mem_ready = r; reset = rs;
    q.push_back({skip, c, CNT_W'(model_cnt)});
  endtask

  task automatic step(input ctl_t c, input logic z, input logic r, input bit ret);
    if (aborted) return;
    if (idx == abort_at_g) begin
      drive(z, r, 1'b1, c, 1'b1);
      model_cnt = 0;
      aborted = 1'b1;
    end else begin
      drive(z, r, 1'b0, c, 1'b0);
      if (ret) model_cnt = (model_cnt + 1) % (1 << CNT_W);
    end
    idx++;
  endtask

  task automatic run_instr(input logic [10:0] o, input int wf, input int wm,
                           input int abort_at, input int ill_cycles, input int zf);
    ctl_t c;
    logic z;
    int   kind;
    kind = classify(o);
    aborted = 1'b0; idx = 0; cur_op = o; abort_at_g = abort_at;
    for (int i = 0; i < wf; i++) begin
      c = '0; c.mem_read = 1'b1; step(c, rz(), 1'b0, 1'b0);
    end
    c = '0; c.mem_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1;
    step(c, rz(), 1'b1, 1'b0);
    c = '0; c.reg2loc = (kind == 2 || kind == 3);
    step(c, rz(), rz(), 1'b0);
    case (kind)
      0: begin
        c = '0; c.alu = r_alu(o); step(c, rz(), rz(), 1'b0);
        c = '0; c.reg_write = 1'b1; step(c, rz(), rz(), 1'b1);
      end
      1: begin
        c = '0; c.alu_src = 1'b1; c.alu = 4'b0010; step(c, rz(), rz(), 1'b0);
        c = '0; c.mem_read = 1'b1; c.iord = 1'b1;
        for (int i = 0; i < wm; i++) step(c, rz(), 1'b0, 1'b0);
        step(c, rz(), 1'b1, 1'b0);
        c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1; step(c, rz(), rz(), 1'b1);
      end
      2: begin
        c = '0; c.alu_src = 1'b1; c.alu = 4'b0010; c.reg2loc = 1'b1;
        step(c, rz(), rz(), 1'b0);
        c = '0; c.mem_write = 1'b1; c.iord = 1'b1; c.reg2loc = 1'b1;
        for (int i = 0; i < wm; i++) step(c, rz(), 1'b0, 1'b0);
        step(c, rz(), 1'b1, 1'b1);
      end
      3: begin
        z = (zf < 0) ? rz() : logic'(zf);
        c = '0; c.reg2loc = 1'b1; c.alu = 4'b0111;
        c.pc_write = z; c.pc_src = z;
        step(c, z, rz(), 1'b1);
      end
      default: begin
        c = '0; c.exc = 1'b1;
        for (int i = 0; i < ill_cycles; i++) step(c, rz(), rz(), 1'b0);
        if (!aborted) begin
          c = '0;
          drive(1'b0, 1'b0, 1'b1, c, 1'b1);
          model_cnt = 0;
        end
      end
    endcase
  endtask

  function automatic logic [10:0] pick_op();
    logic [10:0] o;
    case ($urandom_range(0, 9))
      0, 1, 2: begin
        case ($urandom_range(0, 3))
          0: o = T_ADD;
          1: o = T_SUB;
          2: o = T_AND;
          default: o = T_ORR;
        endcase
      end
      3, 4: o = T_LDUR;
      5, 6: o = T_STUR;
      7, 8: o = {T_CBZ[10:3], 3'($urandom)};
      default: begin
        o = 11'($urandom);
        while (classify(o) != 4) o = 11'($urandom);
      end
    endcase
    return o;
  endfunction

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    run_instr(T_ADD, 0, 0, -1, 0, -1);
    run_instr(T_LDUR, 0, 3, -1, 0, -1);
    run_instr(T_STUR, 0, 0, -1, 0, -1);
    run_instr(T_CBZ, 0, 0, -1, 0, 1);
    run_instr(T_CBZ, 1, 0, -1, 0, 0);
    run_instr(11'b11111111111, 0, 0, -1, 20, -1);
    run_instr(T_LDUR, 0, 0, -1, 0, -1);
    run_instr(T_STUR, 1, 5, 6, 0, -1);
    for (int i = 0; i < 20; i++) run_instr((i % 2 == 0) ? T_ORR : T_SUB, 0, 0, -1, 0, -1);
    for (int i = 0; i < 300; i++)
      run_instr(pick_op(), $urandom_range(0, 2), $urandom_range(0, 3),
                ($urandom_range(0, 19) == 0) ? $urandom_range(0, 6) : -1,
                $urandom_range(1, 5), -1);
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0 pending entries", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
